data_mem_ctrl: RTL

Memory-side responder for the `cpu_core` data-memory port. It accepts the core's `mem_addr`/`mem_wdata`/`mem_ctrl_signal` request, performs a multi-cycle access on the board's 32-bit asynchronous SRAM, returns `mem_rdata`, and holds `mem_stall` high until the access completes. It sits between `cpu_core` and the base-RAM pins in the top level, replacing the behavioural memory used in simulation.

---
 rtl/data_mem_ctrl_pkg.sv | 34 +++
 rtl/data_mem_ctrl_if.sv | 21 ++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the core's data-memory request and the SRAM controller.
package data_mem_ctrl_pkg;

    localparam int MEM_RD_BIT   = 0;
    localparam int MEM_WR_BIT   = 1;
    localparam int MEM_SIGN_BIT = 2;
    localparam int MEM_SZ_LSB   = 3;
    localparam int MEM_SZ_MSB   = 4;

    typedef enum logic [1:0] {
        MEM_SZ_BYTE = 2'b00,
        MEM_SZ_HALF = 2'b01,
        MEM_SZ_WORD = 2'b10,
        MEM_SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mem_state_e;

    // Everything captured when a request is accepted, so the core may change its inputs mid-access.
    typedef struct packed {
        logic [19:0] word_addr;
        logic [3:0]  be_n;
        mem_size_e   size;
        logic        sign;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side data-memory port: request fields from the core, result and stall back.
interface data_mem_ctrl_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_ctrl_signal;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_error;

    modport master (
        output mem_addr, mem_wdata, mem_ctrl_signal,
        input  mem_rdata, mem_stall, mem_error
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_ctrl_signal,
        output mem_rdata, mem_stall, mem_error
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, write-data replication, read extraction/extension.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be_n,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be_n          = 4'hF;
        wdata_aligned = wdata;
        rdata_ext     = rdata_raw;
        misaligned    = 1'b0;

        case (addr_lo)
            2'd0:    rd_byte = rdata_raw[7:0];
            2'd1:    rd_byte = rdata_raw[15:8];
            2'd2:    rd_byte = rdata_raw[23:16];
            default: rd_byte = rdata_raw[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

        case (size)
            MEM_SZ_BYTE: begin
                be_n          = ~(4'b0001 << addr_lo);
                wdata_aligned = {4{wdata[7:0]}};
                rdata_ext     = {{24{sign & rd_byte[7]}}, rd_byte};
            end
            MEM_SZ_HALF: begin
                be_n          = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_aligned = {2{wdata[15:0]}};
                rdata_ext     = {{16{sign & rd_half[15]}}, rd_half};
                misaligned    = addr_lo[0];
            end
            MEM_SZ_WORD: begin
                be_n       = 4'h0;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for cpu_core: multi-cycle access to the 32-bit async base SRAM.
//   state | meaning
//   IDLE  | waiting for a request; legal request stalls the core and is latched
//   READ  | ce_n/oe_n low for WAIT_CYCLES cycles, result captured on the last one
//   WRITE | bus driven; we_n low on all but the last cycle (hold time)
//   DONE  | stall released, core advances; request still on the port is ignored
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_50M,
    input  logic             reset_btn,
    data_mem_ctrl_if.slave   mem,
    output logic [19:0]      base_ram_addr,
    output logic [3:0]       base_ram_be_n,
    output logic             base_ram_ce_n,
    output logic             base_ram_oe_n,
    output logic             base_ram_we_n,
    inout  wire  [31:0]      base_ram_data
);

    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_ctrl: WAIT_CYCLES must be 2..15 (a 1-cycle WRITE never pulses we_n)");
    end

    mem_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_last;
    mem_req_t           req_q;
    logic [31:0]        rdata_q;

    logic               req_rd, req_wr, req_any, req_legal, accept;
    mem_size_e          req_size;
    mem_size_e          la_size;
    logic               la_sign;
    logic [1:0]         la_addr_lo;
    logic [3:0]         la_be_n;
    logic [31:0]        la_wdata, la_rdata;
    logic               la_misaligned;
    logic               drive_bus, stall, error;
    logic               unused_addr_hi;

    assign req_rd   = mem.mem_ctrl_signal[MEM_RD_BIT];
    assign req_wr   = mem.mem_ctrl_signal[MEM_WR_BIT];
    assign req_any  = req_rd | req_wr;
    assign req_size = mem_size_e'(mem.mem_ctrl_signal[MEM_SZ_MSB:MEM_SZ_LSB]);
    assign unused_addr_hi = ^mem.mem_addr[31:22];

    // One aligner serves both ends: live request in IDLE, latched fields while reading.
    assign la_size    = (state == ST_IDLE) ? req_size : req_q.size;
    assign la_sign    = (state == ST_IDLE) ? mem.mem_ctrl_signal[MEM_SIGN_BIT] : req_q.sign;
    assign la_addr_lo = (state == ST_IDLE) ? mem.mem_addr[1:0] : req_q.addr_lo;

    mem_lane_align u_lane_align (
        .size          (la_size),
        .sign          (la_sign),
        .addr_lo       (la_addr_lo),
        .wdata         (mem.mem_wdata),
        .rdata_raw     (base_ram_data),
        .be_n          (la_be_n),
        .wdata_aligned (la_wdata),
        .rdata_ext     (la_rdata),
        .misaligned    (la_misaligned)
    );

    assign req_legal = (req_rd ^ req_wr) && (req_size != MEM_SZ_ILL) && !la_misaligned;
    assign accept    = (state == ST_IDLE) && req_legal;
    assign cnt_last  = (cnt == CNT_LAST);

    always_ff @(posedge clk_50M) begin
        if (reset_btn) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = req_rd ? ST_READ : ST_WRITE;
            ST_READ,
            ST_WRITE: if (cnt_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        base_ram_ce_n = 1'b1;
        base_ram_oe_n = 1'b1;
        base_ram_we_n = 1'b1;
        drive_bus     = 1'b0;
        case (state)
            ST_READ: begin
                base_ram_ce_n = 1'b0;
                base_ram_oe_n = 1'b0;
            end
            ST_WRITE: begin
                base_ram_ce_n = 1'b0;
                base_ram_we_n = cnt_last;
                drive_bus     = 1'b1;
            end
            default: ;
        endcase
        stall = !reset_btn && (accept || state == ST_READ || state == ST_WRITE);
        error = !reset_btn && (state == ST_IDLE) && req_any && !req_legal;
    end

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            cnt        <= '0;
            req_q      <= '0;
            req_q.be_n <= 4'hF;
            rdata_q    <= '0;
        end else begin
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (accept) begin
                    req_q.word_addr <= mem.mem_addr[21:2];
                    req_q.be_n      <= la_be_n;
                    req_q.size      <= req_size;
                    req_q.sign      <= mem.mem_ctrl_signal[MEM_SIGN_BIT];
                    req_q.addr_lo   <= mem.mem_addr[1:0];
                    req_q.wdata     <= la_wdata;
                end
            end else if ((state == ST_READ || state == ST_WRITE) && !cnt_last) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_READ && cnt_last) rdata_q <= la_rdata;
        end
    end

    assign base_ram_addr  = req_q.word_addr;
    assign base_ram_be_n  = req_q.be_n;
    assign base_ram_data  = drive_bus ? req_q.wdata : {32{1'bz}};
    assign mem.mem_rdata  = rdata_q;
    assign mem.mem_stall  = stall;
    assign mem.mem_error  = error;

endmodule
